// File: rtl/bypass_net.sv
// bypass_net: operand forwarding and load-use hazard detection for the ID stage.
// Tracks the destination of the instructions now in EX and MEM, picks the newest
// producer for every ID read port, and requests a one-cycle stall when an
// operand is produced by a load that is still in EX.
module bypass_net #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [NRD*AW-1:0] id_rd_addr,
  input  logic [NRD-1:0]    id_rd_use,
  input  logic [NRD*DW-1:0] id_reg_data,
  input  logic              id_wr_en,
  input  logic [AW-1:0]     id_wr_addr,
  input  logic              id_is_load,
  input  logic [DW-1:0]     exe_result,
  input  logic [DW-1:0]     mem_result,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD*2-1:0]  fwd_sel,
  output logic              stall_id,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] SEL_EX  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_RF  = 2'b00;

  // Tracker for the instruction in EX (one stage after ID).
  logic          ext_vld_p1;
  logic [AW-1:0] ext_waddr_p1;
  logic          ext_load_p1;

  // Tracker for the instruction in MEM (two stages after ID).
  logic          mem_vld_p2;
  logic [AW-1:0] mem_waddr_p2;
  logic          mem_load_p2;

  logic [15:0]   stall_cnt_q;

  // Per-port hit flags evaluated in ID.
  logic [NRD-1:0] ex_hit_p0;
  logic [NRD-1:0] mem_hit_p0;
  logic [NRD-1:0] load_use_p0;
  logic           bubble_p0;

  // Saturating increment: the stall counter sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- ID stage: hit detection and operand select (combinational) ----
  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] addr;
    logic          addr_nz;
    logic [1:0]    sel;

    assign addr    = id_rd_addr[k*AW +: AW];
    // r0 is hard-wired zero and must never be forwarded.
    assign addr_nz = |addr;

    assign ex_hit_p0[k]   = id_rd_use[k] & ext_vld_p1 & (ext_waddr_p1 == addr) & addr_nz;
    assign mem_hit_p0[k]  = id_rd_use[k] & mem_vld_p2 & (mem_waddr_p2 == addr) & addr_nz;
    // A load in EX has no data yet; the reader has to wait one cycle.
    assign load_use_p0[k] = ex_hit_p0[k] & ext_load_p1;

    // EX is the newest producer, so it wins over MEM unless it is a load.
    assign sel = (ex_hit_p0[k] && !ext_load_p1) ? SEL_EX  :
                 mem_hit_p0[k]                  ? SEL_MEM : SEL_RF;

    assign fwd_sel[2*k +: 2]   = sel;
    assign rd_data[k*DW +: DW] = (sel == SEL_EX)  ? exe_result :
                                 (sel == SEL_MEM) ? mem_result :
                                                    id_reg_data[k*DW +: DW];
  end

  assign stall_id  = id_valid & (|load_use_p0);
  // Stalled, flushed or empty ID slots all enter EX as the same bubble.
  assign bubble_p0 = stall_id | flush | ~id_valid;
  assign stall_cnt = stall_cnt_q;

  // ---- ID -> EX -> MEM: tracker advance and stall counting ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_vld_p1   <= 1'b0;
      ext_waddr_p1 <= '0;
      ext_load_p1  <= 1'b0;
      mem_vld_p2   <= 1'b0;
      mem_waddr_p2 <= '0;
      mem_load_p2  <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else if (!ext_stall) begin
      mem_vld_p2   <= ext_vld_p1;
      mem_waddr_p2 <= ext_waddr_p1;
      mem_load_p2  <= ext_load_p1;
      if (bubble_p0) begin
        ext_vld_p1   <= 1'b0;
        ext_waddr_p1 <= '0;
        ext_load_p1  <= 1'b0;
      end else begin
        ext_vld_p1   <= id_wr_en;
        ext_waddr_p1 <= id_wr_addr;
        ext_load_p1  <= id_is_load;
      end
      if (stall_id) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
    end
  end

  // MEM-stage load flag is tracked for completeness of the entry but the
  // load result is already on mem_result by then, so no decision uses it.
  logic unused_mem_load;
  assign unused_mem_load = mem_load_p2;

endmodule

// File: tb/tb_bypass_net.sv
// Directed bench for bypass_net: each step drives one ID-stage cycle, pushes
// the expected outputs to a scoreboard and compares on the falling edge.
module tb_bypass_net;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  localparam logic [DW-1:0] REG0 = 32'hA0A0_0A0A;
  localparam logic [DW-1:0] REG1 = 32'hB1B1_0B1B;

  logic              clk = 1'b0;
  logic              rst;
  logic              ext_stall;
  logic              flush;
  logic              id_valid;
  logic [NRD*AW-1:0] id_rd_addr;
  logic [NRD-1:0]    id_rd_use;
  logic [NRD*DW-1:0] id_reg_data;
  logic              id_wr_en;
  logic [AW-1:0]     id_wr_addr;
  logic              id_is_load;
  logic [DW-1:0]     exe_result;
  logic [DW-1:0]     mem_result;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD*2-1:0]  fwd_sel;
  logic              stall_id;
  logic [15:0]       stall_cnt;

  typedef struct {
    string         tag;
    logic [3:0]    sel;
    logic [63:0]   data;
    logic          stall;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bypass_net #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_stall  (ext_stall),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rd_addr (id_rd_addr),
    .id_rd_use  (id_rd_use),
    .id_reg_data(id_reg_data),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_is_load (id_is_load),
    .exe_result (exe_result),
    .mem_result (mem_result),
    .rd_data    (rd_data),
    .fwd_sel    (fwd_sel),
    .stall_id   (stall_id),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive one ID-stage instruction (called just after a rising edge).
  task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                       input logic ld, input logic [4:0] a0, input logic u0,
                       input logic [4:0] a1, input logic u1, input logic fl);
    id_valid   = v;
    id_wr_en   = we;
    id_wr_addr = wa;
    id_is_load = ld;
    id_rd_addr = {a1, a0};
    id_rd_use  = {u1, u0};
    flush      = fl;
  endtask

  // Push the expectation, wait for the falling edge, pop and compare.
  task automatic chk(input string tag, input logic [3:0] sel,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic st, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.data = {d1, d0}; e.stall = st; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    assert (fwd_sel === e.sel) else begin
      n_bad++;
      $error("FAIL %s fwd_sel observed=%b expected=%b", e.tag, fwd_sel, e.sel);
    end
    n_cmp++;
    assert (rd_data === e.data) else begin
      n_bad++;
      $error("FAIL %s rd_data observed=%h expected=%h", e.tag, rd_data, e.data);
    end
    n_cmp++;
    assert (stall_id === e.stall) else begin
      n_bad++;
      $error("FAIL %s stall_id observed=%b expected=%b", e.tag, stall_id, e.stall);
    end
    n_cmp++;
    assert (stall_cnt === e.cnt) else begin
      n_bad++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0;
    id_reg_data = {REG1, REG0};
    exe_result = '0; mem_result = '0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty trackers after reset; add r3 enters ID.
    drive(1, 1, 5'd3, 0, 5'd3, 1, 5'd3, 1, 0);
    chk("reset_state", 4'b0000, REG0, REG1, 0, 16'd0);

    // Back-to-back ALU reader of r3 on port 0; writer r4.
    next_cycle(); exe_result = 32'h1234; mem_result = 32'hDEAD_0000;
    drive(1, 1, 5'd4, 0, 5'd3, 1, 5'd9, 1, 0);
    chk("alu_b2b", 4'b0010, 32'h1234, REG1, 0, 16'd0);

    // Independent op: r3 now in MEM; port 1 hits EX r4 but is unused.
    next_cycle(); exe_result = 32'h5555; mem_result = 32'h7777;
    drive(1, 1, 5'd8, 0, 5'd3, 1, 5'd4, 0, 0);
    chk("mem_hit_unused", 4'b0001, 32'h7777, REG1, 0, 16'd0);

    // Distance 2 reader of r4 on port 1.
    next_cycle(); exe_result = 32'h1111; mem_result = 32'hBEEF;
    drive(1, 1, 5'd5, 0, 5'd0, 0, 5'd4, 1, 0);
    chk("dist2", 4'b0100, REG0, 32'hBEEF, 0, 16'd0);

    // Second writer of r5; port 0 reads r8 from MEM, port 1 reads r5 from EX.
    next_cycle(); exe_result = 32'hAAAA; mem_result = 32'hBBBB;
    drive(1, 1, 5'd5, 0, 5'd8, 1, 5'd5, 1, 0);
    chk("mixed_ports", 4'b1001, 32'hBBBB, 32'hAAAA, 0, 16'd0);

    // r5 in both EX and MEM: EX wins. lw r6 enters ID.
    next_cycle(); exe_result = 32'hC0C0; mem_result = 32'hD0D0;
    drive(1, 1, 5'd6, 1, 5'd5, 1, 5'd5, 1, 0);
    chk("priority", 4'b1010, 32'hC0C0, 32'hC0C0, 0, 16'd0);

    // Load-use cycle 1: stall; port 1 still gets r5 from MEM.
    next_cycle(); exe_result = 32'hE1E1; mem_result = 32'hE2E2;
    drive(1, 1, 5'd9, 0, 5'd6, 1, 5'd5, 1, 0);
    chk("loaduse_c1", 4'b0100, REG0, 32'hE2E2, 1, 16'd0);

    // Load-use cycle 2: load now in MEM, forwarded via 01.
    next_cycle(); exe_result = 32'hE3E3; mem_result = 32'h600D_F00D;
    drive(1, 1, 5'd9, 0, 5'd6, 1, 5'd5, 0, 0);
    chk("loaduse_c2", 4'b0001, 32'h600D_F00D, REG1, 0, 16'd1);

    // Writer of r0; port 0 forwards r9 from EX.
    next_cycle(); exe_result = 32'h9999; mem_result = 32'h8888;
    drive(1, 1, 5'd0, 0, 5'd9, 1, 5'd0, 1, 0);
    chk("r0_writer", 4'b0010, 32'h9999, REG1, 0, 16'd1);

    // Reader of r0 on both ports behind the r0 writer; this one is flushed (writes r7).
    next_cycle(); exe_result = 32'hFFFF_0000; mem_result = 32'hFFFF_1111;
    id_reg_data = '0;
    drive(1, 1, 5'd7, 0, 5'd0, 1, 5'd0, 1, 1);
    chk("r0_read", 4'b0000, 32'h0, 32'h0, 0, 16'd1);

    // Reader of r7 after the flushed writer; this op has wr_en=0 with waddr r7.
    next_cycle(); id_reg_data = {REG1, REG0};
    drive(1, 0, 5'd7, 0, 5'd7, 1, 5'd0, 1, 0);
    chk("flushed_r7", 4'b0000, REG0, REG1, 0, 16'd1);

    // Invalid EX entry holding waddr r7 must not hit; lw r10 enters ID.
    next_cycle(); exe_result = 32'h7070; mem_result = 32'h0707;
    drive(1, 1, 5'd10, 1, 5'd7, 1, 5'd7, 1, 0);
    chk("invalid_entry", 4'b0000, REG0, REG1, 0, 16'd1);

    // Pending load-use on r10 frozen by ext_stall for three cycles.
    next_cycle(); ext_stall = 1'b1;
    drive(1, 1, 5'd11, 0, 5'd10, 1, 5'd0, 0, 0);
    chk("freeze_1", 4'b0000, REG0, REG1, 1, 16'd1);
    next_cycle();
    chk("freeze_2", 4'b0000, REG0, REG1, 1, 16'd1);
    next_cycle();
    chk("freeze_3", 4'b0000, REG0, REG1, 1, 16'd1);

    // Reset mid-stall: visible from the next cycle.
    next_cycle(); rst = 1'b1;
    chk("rst_asserted", 4'b0000, REG0, REG1, 1, 16'd1);
    next_cycle(); rst = 1'b0; ext_stall = 1'b0;
    chk("after_rst", 4'b0000, REG0, REG1, 0, 16'd0);

    // lw r12; port 0 forwards r11 (from the post-reset op) out of EX.
    next_cycle(); exe_result = 32'h1B1B; mem_result = 32'h2C2C;
    drive(1, 1, 5'd12, 1, 5'd11, 1, 5'd0, 0, 0);
    chk("lw_r12", 4'b0010, 32'h1B1B, REG1, 0, 16'd0);

    // Load-use together with flush: one bubble, one count.
    next_cycle(); exe_result = 32'h3D3D; mem_result = 32'h4E4E;
    drive(1, 1, 5'd13, 0, 5'd12, 1, 5'd11, 1, 1);
    chk("flush_stall", 4'b0100, REG0, 32'h4E4E, 1, 16'd0);

    next_cycle(); exe_result = 32'h5F5F; mem_result = 32'h6A6A;
    drive(1, 0, 5'd0, 0, 5'd12, 1, 5'd11, 1, 0);
    chk("flush_stall_after", 4'b0001, 32'h6A6A, REG1, 0, 16'd1);

    // ID empty: a load-use match must not request a stall.
    next_cycle();
    drive(1, 1, 5'd14, 1, 5'd0, 0, 5'd0, 0, 0);
    chk("lw_r14", 4'b0000, REG0, REG1, 0, 16'd1);
    next_cycle();
    drive(0, 0, 5'd0, 0, 5'd14, 1, 5'd0, 0, 0);
    chk("no_valid_no_stall", 4'b0000, REG0, REG1, 0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bypass_net.md
BYPASS_NET -- requirements
Module: bypass_net

Interface
REQ-001 Parameter DW, default 32: width of a register data word.
REQ-002 Parameter AW, default 5: width of a register address.
REQ-003 Parameter NRD, default 2: number of ID-stage read ports.
REQ-004 Port clk  input  1: the single clock; every state element updates on the rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port ext_stall  input  1: global pipeline freeze.
REQ-007 Port flush  input  1: kill the instruction currently in ID.
REQ-008 Port id_valid  input  1: the ID stage holds an instruction.
REQ-009 Port id_rd_addr  input  NRD*AW: read addresses; port k occupies bits [k*AW +: AW].
REQ-010 Port id_rd_use  input  NRD: per-port flag that the operand is actually read.
REQ-011 Port id_reg_data  input  NRD*DW: register-file read data, packed per port.
REQ-012 Port id_wr_en  input  1: the ID instruction writes a register.
REQ-013 Port id_wr_addr  input  AW: destination address of the ID instruction.
REQ-014 Port id_is_load  input  1: the ID instruction is a load.
REQ-015 Port exe_result  input  DW: EX-stage ALU output.
REQ-016 Port mem_result  input  DW: MEM-stage result, either ALU output or load data.
REQ-017 Port rd_data  output  NRD*DW: forwarded operands, packed per port.
REQ-018 Port fwd_sel  output  NRD*2: per-port source; 2'b10 = EX, 2'b01 = MEM, 2'b00 = register file.
REQ-019 Port stall_id  output  1: load-use stall request for the IF and ID stages.
REQ-020 Port stall_cnt  output  16: saturating count of load-use stall cycles.

Function
REQ-021 The block SHALL hold two tracker entries, EXT and MEMT; each entry is {valid, waddr[AW], is_load}.
REQ-022 For each port k, the EX hit condition SHALL be: id_rd_use[k], EXT.valid, EXT.waddr == addr_k, and addr_k != 0.
REQ-023 The MEM hit condition SHALL be the same as REQ-022, using MEMT instead of EXT.
REQ-024 Forwarding select priority per port SHALL be:
  - EX hit and not EXT.is_load -> 2'b10, exe_result;
  - else MEM hit -> 2'b01, mem_result;
  - else -> 2'b00, id_reg_data.
REQ-025 rd_data and fwd_sel SHALL be combinational from the current tracker state and the current inputs, with zero-cycle latency.
REQ-026 Address 0 SHALL never be forwarded; it always selects 2'b00, including when a tracker entry has waddr 0.
REQ-027 stall_id SHALL be 1 when id_valid and, for any port k, the EX hit holds with EXT.is_load = 1.
REQ-028 stall_id SHALL be combinational, is independent of flush and ext_stall, and is 0 when id_valid = 0.
REQ-029 On each rising edge with rst = 0 and ext_stall = 1, EXT, MEMT and stall_cnt SHALL hold their values.
REQ-030 On each rising edge with rst = 0 and ext_stall = 0, the trackers SHALL advance:
  - MEMT <= EXT;
  - EXT <= bubble (valid = 0) if stall_id, flush or !id_valid;
  - otherwise EXT <= {id_wr_en, id_wr_addr, id_is_load}.
REQ-031 A load-use hazard SHALL produce exactly one stall cycle: the bubble leaves the load in MEMT on the next cycle, where it forwards through 2'b01.
REQ-032 When flush and stall_id are both 1, the bubble SHALL be inserted once, with no double effect; stall_id still asserts that cycle.
REQ-033 stall_cnt SHALL increment by 1 on each edge where stall_id = 1, ext_stall = 0 and rst = 0.
REQ-034 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-035 An entry with valid = 0 SHALL never produce a hit, whatever its waddr.

Reset
REQ-036 On a rising edge with rst = 1, EXT and MEMT SHALL become all-zero (valid = 0) and stall_cnt SHALL become 0.
REQ-037 rst SHALL take priority over ext_stall and flush, including a reset in the middle of a stall.
REQ-038 After reset, with no writers tracked, every fwd_sel SHALL be 2'b00, rd_data SHALL equal id_reg_data and stall_id SHALL be 0.

Verification
REQ-039 ALU back-to-back: issue add r3, then a reader of r3 on port 0 with exe_result = 32'h1234 -> fwd_sel[1:0] = 2'b10, rd_data port 0 = 32'h1234, stall_id = 0.
REQ-040 Distance 2: writer r4, independent op, then reader of r4 on port 1 with mem_result = 32'hBEEF -> port 1 select 2'b01, data 32'hBEEF.
REQ-041 Priority: EXT and MEMT both write r5, reader of r5 -> select 2'b10 (EX wins).
REQ-042 Load-use: lw r6, then reader of r6:
  - cycle 1: stall_id = 1, stall_cnt 0 -> 1;
  - cycle 2: stall_id = 0, select 2'b01, load data forwarded.
REQ-043 r0 and invalid entries: writer with waddr 0, then reader of r0 with id_reg_data = 0 -> select 2'b00, data 0; the same holds for a flushed writer of r7 read by the next instruction.
REQ-044 ext_stall and reset: pending load-use with ext_stall = 1 for 3 cycles -> trackers and stall_cnt frozen, stall_id remains 1; asserting rst mid-stall -> stall_cnt = 0, stall_id = 0 on the next cycle.
